// File: rtl/product_display.sv
// Converts an 8-bit product to three BCD digits by double-dabble and scans them onto a 4-digit 7-segment display.
// Latency: done rises 8 cycles after the edge that samples load; seg/an follow bcd one cycle later.
// Backpressure: none; load is ignored while a conversion or its done cycle is in progress.
module product_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  product,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [7:0]  shift_q;
    logic [11:0] scratch_q;
    logic [2:0]  iter_q;
    logic [11:0] bcd_q;
    logic        busy_q;
    logic        done_q;

    logic [11:0] adj;
    logic [19:0] shifted;
    logic [11:0] scratch_d;
    logic [7:0]  shift_d;

    // Active-low 7-segment code {g,f,e,d,c,b,a}; non-decimal codes are dark.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // One double-dabble step: correct any digit >= 5, then shift the combined register left.
    always_comb begin
        adj         = scratch_q;
        if (scratch_q[3:0]  >= 4'd5) adj[3:0]  = scratch_q[3:0]  + 4'd3;
        if (scratch_q[7:4]  >= 4'd5) adj[7:4]  = scratch_q[7:4]  + 4'd3;
        if (scratch_q[11:8] >= 4'd5) adj[11:8] = scratch_q[11:8] + 4'd3;
        shifted   = {adj, shift_q} << 1;
        scratch_d = shifted[19:8];
        shift_d   = shifted[7:0];
    end

    // Conversion FSM with registered busy/done and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (load) begin
                        shift_q   <= product;
                        scratch_q <= '0;
                        iter_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    iter_q    <= iter_q + 3'd1;
                    // The eighth step's shifted scratch is the finished result.
                    if (iter_q == 3'd7) begin
                        bcd_q   <= scratch_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scanning
    // ------------------------------------------------------------------
    logic [CW-1:0] scan_q;
    logic [CW-1:0] scan_d;
    logic [1:0]    idx_q;
    logic [1:0]    idx_d;
    logic [6:0]    seg_q;
    logic [6:0]    seg_d;
    logic [3:0]    an_q;
    logic [3:0]    an_d;
    logic [3:0]    code;
    logic          show;

    // Next scan position and the segment/anode pattern for that position,
    // so registered seg/an switch on the same edge as the digit index.
    always_comb begin
        if (scan_q == SCAN_MAX) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end else begin
            scan_d = scan_q + 1'b1;
            idx_d  = idx_q;
        end

        code = 4'd0;
        show = 1'b0;
        case (idx_d)
            2'd0: begin
                code = bcd_q[3:0];
                show = 1'b1;
            end
            2'd1: begin
                code = bcd_q[7:4];
                show = (bcd_q[11:8] != 4'd0) || (bcd_q[7:4] != 4'd0);
            end
            2'd2: begin
                code = bcd_q[11:8];
                show = (bcd_q[11:8] != 4'd0);
            end
            default: begin
                code = 4'd0;
                show = 1'b0;
            end
        endcase

        seg_d = show ? seg_enc(code) : SEG_BLANK;
        an_d  = ~(4'b0001 << idx_d);
    end

    // Free-running scan counter and registered display drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= 2'd0;
            seg_q  <= SEG_ZERO;
            an_q   <= 4'b1110;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_product_display.sv
module tb_product_display;

    logic        clk;
    logic        rst;
    logic [7:0]  product;
    logic        load;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int n_vec;
    int n_err;

    localparam logic [6:0] BLK = 7'b1111111;

    product_display #(.SCAN_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .product (product),
        .load    (load),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .seg     (seg),
        .an      (an),
        .dp      (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load one product, wait (bounded) for done, check result and timing.
    task automatic convert(input logic [7:0] p, input logic [11:0] exp, input bit full, input string tag);
        int lat;
        int bc;
        product = p;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        lat = 0;
        bc  = 0;
        while (!done && lat < 20) begin
            if (busy) bc++;
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 8);
        check({tag, "_bcd"}, bcd, exp);
        if (full) begin
            check({tag, "_busycyc"}, bc, 8);
            check({tag, "_busy_at_done"}, busy, 0);
        end
        tick();
        if (full) check({tag, "_done_pulse"}, done, 0);
    endtask

    // Lock onto the start of digit slot 0, then check a full 4-slot scan.
    task automatic scan_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [3:0] prev;
        bit         found;
        logic [6:0] exps [4];
        logic [3:0] expa [4];
        exps  = '{s0, s1, s2, s3};
        expa  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = an;
            tick();
            if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
        end
        check({tag, "_sync"}, found, 1);
        check({tag, "_dp"}, dp, 1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_an%0d", tag, k), an, expa[k/4]);
            check($sformatf("%s_seg%0d", tag, k), seg, exps[k/4]);
            tick();
        end
    endtask

    initial begin
        int n_done;
        int done_at;
        logic [11:0] r;

        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        load    = 1'b0;
        product = 8'd0;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd",  bcd,  12'h000);
        check("rst_an",   an,   4'b1110);
        check("rst_seg",  seg,  7'b1000000);
        check("rst_dp",   dp,   1);
        rst = 1'b0;
        tick();

        // 15 x 15
        convert(8'd225, 12'h225, 1'b1, "p225");
        scan_check("scan225", 7'b0010010, 7'b0100100, 7'b0100100, BLK);

        // Zero: only units digit lit
        convert(8'd0, 12'h000, 1'b1, "p0");
        scan_check("scan0", 7'b1000000, BLK, BLK, BLK);

        // Maximum
        convert(8'd255, 12'h255, 1'b1, "p255");

        // Second load during SHIFT must be ignored; old bcd holds meanwhile
        product = 8'd6;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        tick();
        product = 8'd9;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        check("ign_busy", busy, 1);
        check("ign_bcd_hold", bcd, 12'h255);
        n_done  = 0;
        done_at = -1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) begin
                n_done++;
                done_at = i;
            end
        end
        check("ign_ndone", n_done, 1);
        check("ign_done_at", done_at, 5);
        check("ign_bcd", bcd, 12'h006);
        check("ign_busy_end", busy, 0);

        // Reset in the 4th SHIFT cycle aborts the conversion
        product = 8'd200;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bcd",  bcd,  12'h000);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) n_done++;
        end
        check("abort_nodone", n_done, 0);
        check("abort_bcd_after", bcd, 12'h000);
        convert(8'd4, 12'h004, 1'b1, "p4");

        // Scan pattern for 45
        convert(8'd45, 12'h045, 1'b1, "p45");
        scan_check("scan45", 7'b0010010, 7'b0011001, BLK, BLK);

        // Exhaustive sweep against a decimal split
        for (int p = 0; p < 256; p++) begin
            r = 12'(((p / 100) * 256) + (((p / 10) % 10) * 16) + (p % 10));
            convert(8'(p), r, 1'b0, $sformatf("sweep%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
